// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, oversampling ratio and parity modes.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   localparam int UART_OVERSAMPLE  = 16;
   localparam int UART_PARITY_EVEN = 0;
   localparam int UART_PARITY_ODD  = 1;

endpackage

// File: rtl/uart_transmitter_bit_timer.sv
// Bit-period timer: counts tx_clk cycles within one UART bit and strobes bit_end on the last one.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_OVERSAMPLE
) (
   input  logic tx_clk,
   input  logic reset,
   input  logic restart,
   output logic bit_end
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] sample_cnt;

   always_ff @(posedge tx_clk) begin
      if (reset || restart || bit_end) begin
         sample_cnt <= '0;
      end else begin
         sample_cnt <= sample_cnt + CNT_W'(1);
      end
   end

   assign bit_end = (sample_cnt == LAST_SAMPLE);

endmodule

// File: rtl/uart_transmitter.sv
// UART frame serialiser: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_OVERSAMPLE,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = UART_PARITY_EVEN,
   parameter int STOP_BITS    = 1
) (
   input  logic       tx_clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_serial,
   output logic       tx_busy,
   output logic       tx_done
);

   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_transmitter: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
      $error("uart_transmitter: DATA_BITS must be 5..8");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_transmitter: STOP_BITS must be 1 or 2");
   end

   localparam int BIT_CNT_W = $clog2(DATA_BITS);
   localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

   function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
      return (PARITY_ODD == UART_PARITY_ODD) ? ~^d : ^d;
   endfunction

   uart_tx_state_t         state_q,   state_nxt;
   logic [DATA_BITS-1:0]   shift_q,   shift_nxt;
   logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_nxt;
   logic                   par_q,     par_nxt;
   logic                   serial_q,  serial_nxt;
   logic                   done_q,    done_nxt;
   logic                   accept;
   logic                   bit_end;

   assign tx_ready  = (state_q == IDLE);
   assign tx_busy   = (state_q != IDLE);
   assign tx_serial = serial_q;
   assign tx_done   = done_q;
   assign accept    = tx_valid & tx_ready;

   // Timer is held at zero while idle so the start bit gets a full period from the accept edge.
   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .tx_clk  (tx_clk),
      .reset   (reset),
      .restart (state_q == IDLE),
      .bit_end (bit_end)
   );

   always_ff @(posedge tx_clk) begin
      if (reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         par_q     <= 1'b0;
         serial_q  <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         shift_q   <= shift_nxt;
         bit_cnt_q <= bit_cnt_nxt;
         par_q     <= par_nxt;
         serial_q  <= serial_nxt;
         done_q    <= done_nxt;
      end
   end

   always_comb begin
      state_nxt   = state_q;
      shift_nxt   = shift_q;
      bit_cnt_nxt = bit_cnt_q;
      par_nxt     = par_q;
      serial_nxt  = serial_q;
      done_nxt    = 1'b0;

      case (state_q)
         IDLE: begin
            serial_nxt = 1'b1;
            if (accept) begin
               state_nxt   = START;
               shift_nxt   = tx_data[DATA_BITS-1:0];
               par_nxt     = frame_parity(tx_data[DATA_BITS-1:0]);
               bit_cnt_nxt = '0;
               serial_nxt  = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt   = DATA;
               serial_nxt  = shift_q[0];
               shift_nxt   = shift_q >> 1;
               bit_cnt_nxt = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == LAST_DATA) begin
                  bit_cnt_nxt = '0;
                  if (PARITY_EN != 0) begin
                     state_nxt  = PARITY;
                     serial_nxt = par_q;
                  end else begin
                     state_nxt  = STOP;
                     serial_nxt = 1'b1;
                  end
               end else begin
                  bit_cnt_nxt = bit_cnt_q + BIT_CNT_W'(1);
                  serial_nxt  = shift_q[0];
                  shift_nxt   = shift_q >> 1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_nxt   = STOP;
               serial_nxt  = 1'b1;
               bit_cnt_nxt = '0;
            end
         end
         STOP: begin
            serial_nxt = 1'b1;
            if (bit_end) begin
               if (bit_cnt_q == LAST_STOP) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end else begin
                  bit_cnt_nxt = bit_cnt_q + BIT_CNT_W'(1);
               end
            end
         end
         default: begin
            state_nxt  = IDLE;
            serial_nxt = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: four parameter variants, frames decoded from tx_serial.
module tb_uart_transmitter;

   typedef struct {
      logic [7:0] data;
      logic       par;
      int         gap;
      bit         abort;
   } exp_t;

   logic       tx_clk = 1'b0;
   logic       reset  = 1'b1;
   logic       valid_a  [4];
   logic [7:0] data_a   [4];
   logic       ready_a  [4];
   logic       serial_a [4];
   logic       busy_a   [4];
   logic       done_a   [4];

   exp_t exp_q [4][$];
   int   vectors = 0;
   int   fails   = 0;

   always #5 tx_clk = ~tx_clk;

   uart_transmitter u_dut0 (
      .tx_clk(tx_clk), .reset(reset), .tx_data(data_a[0]), .tx_valid(valid_a[0]),
      .tx_ready(ready_a[0]), .tx_serial(serial_a[0]), .tx_busy(busy_a[0]), .tx_done(done_a[0]));

   uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
      .tx_clk(tx_clk), .reset(reset), .tx_data(data_a[1]), .tx_valid(valid_a[1]),
      .tx_ready(ready_a[1]), .tx_serial(serial_a[1]), .tx_busy(busy_a[1]), .tx_done(done_a[1]));

   uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
      .tx_clk(tx_clk), .reset(reset), .tx_data(data_a[2]), .tx_valid(valid_a[2]),
      .tx_ready(ready_a[2]), .tx_serial(serial_a[2]), .tx_busy(busy_a[2]), .tx_done(done_a[2]));

   uart_transmitter #(.STOP_BITS(2)) u_dut3 (
      .tx_clk(tx_clk), .reset(reset), .tx_data(data_a[3]), .tx_valid(valid_a[3]),
      .tx_ready(ready_a[3]), .tx_serial(serial_a[3]), .tx_busy(busy_a[3]), .tx_done(done_a[3]));

   function automatic int stop_of(input int k);
      return (k == 3) ? 2 : 1;
   endfunction

   function automatic bit par_en_of(input int k);
      return (k == 1) || (k == 2);
   endfunction

   function automatic void check(input string name, input int k,
                                 input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s dut%0d: got 0x%0h, required 0x%0h", name, k, act, req);
      end
   endfunction

   task automatic expect_frame(input int k, input logic [7:0] d, input logic p,
                               input int gap, input bit abort);
      exp_t e;
      e.data  = d;
      e.par   = p;
      e.gap   = gap;
      e.abort = abort;
      exp_q[k].push_back(e);
   endtask

   // Samples n cycles of one bit period; value is the first sample, any change or tx_done counts.
   task automatic period(input int k, input int n, output logic v, output int unstable,
                         output bit ab);
      ab = 0;
      unstable = 0;
      v = 1'bx;
      for (int i = 0; i < n; i++) begin
         @(negedge tx_clk);
         if (reset) begin
            ab = 1;
            return;
         end
         if (i == 0) v = serial_a[k];
         else if (serial_a[k] !== v) unstable++;
         if (done_a[k] !== 1'b0) unstable++;
      end
   endtask

   task automatic monitor(input int k);
      int         idle;
      int         gap;
      int         bad;
      int         u;
      exp_t       e;
      bit         have;
      bit         ab;
      logic       v;
      logic       start_v;
      logic       pbit;
      logic [7:0] obs;
      bit         stop_ok;
      logic       done_seen;
      idle = -1;
      forever begin
         @(negedge tx_clk);
         if (reset) begin
            idle = -1;
         end else if (done_a[k] !== 1'b0) begin
            check("spurious_done", k, 1, 0);
         end else if (serial_a[k] === 1'b1) begin
            if (idle >= 0) idle++;
         end else begin
            gap  = (idle >= 0) ? stop_of(k) * 16 + 1 + idle : -1;
            have = (exp_q[k].size() != 0);
            if (have) e = exp_q[k].pop_front();
            else check("unexpected_frame", k, 1, 0);
            bad = 0; obs = '0; pbit = 1'bx; stop_ok = 1; done_seen = 1'b0; start_v = 1'bx;
            period(k, 15, start_v, u, ab);
            bad += u;
            for (int i = 0; i < 8 && !ab; i++) begin
               period(k, 16, v, u, ab);
               obs[i] = v;
               bad += u;
            end
            if (!ab && par_en_of(k)) begin
               period(k, 16, pbit, u, ab);
               bad += u;
            end
            for (int s = 0; s < stop_of(k) && !ab; s++) begin
               period(k, 16, v, u, ab);
               bad += u;
               if (v !== 1'b1) stop_ok = 0;
            end
            if (!ab) begin
               @(negedge tx_clk);
               if (reset) ab = 1;
               else done_seen = done_a[k];
            end
            if (have) begin
               check("frame_aborted", k, 32'(ab), 32'(e.abort));
               if (!ab && !e.abort) begin
                  check("start_bit", k, 32'(start_v), 0);
                  check("data_byte", k, 32'(obs), 32'(e.data));
                  if (par_en_of(k)) check("parity_bit", k, 32'(pbit), 32'(e.par));
                  check("stop_bits", k, 32'(stop_ok), 1);
                  check("bit_timing", k, bad, 0);
                  check("done_at_frame_end", k, 32'(done_seen), 1);
                  if (e.gap >= 0) check("idle_gap", k, gap, e.gap);
               end
            end
            idle = ab ? -1 : 0;
         end
      end
   endtask

   task automatic send(input int k, input logic [7:0] b);
      bit got;
      @(posedge tx_clk); #1;
      valid_a[k] = 1'b1;
      data_a[k]  = b;
      got = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge tx_clk);
         got = ready_a[k];
      end
      if (!got) check("accept_timeout", k, 0, 1);
      @(posedge tx_clk); #1;
      valid_a[k] = 1'b0;
   endtask

   task automatic wait_done(input int k);
      bit got;
      got = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge tx_clk);
         got = done_a[k];
      end
      if (!got) check("done_timeout", k, 0, 1);
   endtask

   initial begin
      int  low_cnt;
      bit  got;
      for (int k = 0; k < 4; k++) begin
         valid_a[k] = 1'b0;
         data_a[k]  = 8'h00;
      end
      fork
         monitor(0);
         monitor(1);
         monitor(2);
         monitor(3);
      join_none

      repeat (3) @(posedge tx_clk);
      @(negedge tx_clk);
      for (int k = 0; k < 4; k++) begin
         check("reset_serial", k, 32'(serial_a[k]), 1);
         check("reset_ready",  k, 32'(ready_a[k]),  1);
         check("reset_busy",   k, 32'(busy_a[k]),   0);
         check("reset_done",   k, 32'(done_a[k]),   0);
      end
      @(posedge tx_clk); #1;
      reset = 1'b0;
      repeat (4) @(posedge tx_clk);

      // Default frame
      expect_frame(0, 8'hA5, 1'b0, -1, 0);
      send(0, 8'hA5);
      wait_done(0);

      // Back-to-back with tx_valid held: ready only in the two accept cycles
      expect_frame(0, 8'h00, 1'b0, -1, 0);
      expect_frame(0, 8'hFF, 1'b0, 17, 0);
      @(posedge tx_clk); #1;
      valid_a[0] = 1'b1;
      data_a[0]  = 8'h00;
      got = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge tx_clk);
         got = ready_a[0];
      end
      check("b2b_first_accept", 0, 32'(got), 1);
      @(posedge tx_clk); #1;
      data_a[0] = 8'hFF;
      low_cnt = 0;
      got = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge tx_clk);
         if (ready_a[0]) got = 1;
         else low_cnt++;
      end
      check("b2b_ready_low_cycles", 0, low_cnt, 160);
      @(posedge tx_clk); #1;
      valid_a[0] = 1'b0;
      wait_done(0);

      // Parity: 0x07 has three ones
      expect_frame(1, 8'h07, 1'b1, -1, 0);
      send(1, 8'h07);
      wait_done(1);
      expect_frame(2, 8'h07, 1'b0, -1, 0);
      send(2, 8'h07);
      wait_done(2);
      expect_frame(1, 8'h00, 1'b0, -1, 0);
      send(1, 8'h00);
      wait_done(1);

      // Two stop bits
      expect_frame(3, 8'h3C, 1'b0, -1, 0);
      send(3, 8'h3C);
      wait_done(3);

      // Reset in cycle 50 of a frame
      expect_frame(0, 8'h5A, 1'b0, -1, 1);
      send(0, 8'h5A);
      repeat (50) @(posedge tx_clk);
      #1 reset = 1'b1;
      @(posedge tx_clk);
      #1 reset = 1'b0;
      @(negedge tx_clk);
      check("midreset_serial", 0, 32'(serial_a[0]), 1);
      check("midreset_ready",  0, 32'(ready_a[0]),  1);
      check("midreset_busy",   0, 32'(busy_a[0]),   0);
      check("midreset_done",   0, 32'(done_a[0]),   0);
      expect_frame(0, 8'hC3, 1'b0, -1, 0);
      send(0, 8'hC3);
      wait_done(0);

      // tx_data changes while busy
      expect_frame(0, 8'h11, 1'b0, -1, 0);
      send(0, 8'h11);
      repeat (20) @(posedge tx_clk);
      #1 data_a[0] = 8'hEE;
      wait_done(0);

      repeat (20) @(negedge tx_clk);
      for (int k = 0; k < 4; k++) begin
         check("frames_outstanding", k, exp_q[k].size(), 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
